rmii_rx_framer: RTL and testbench
=================================

# rmii_rx_framer

Receive-side RMII framer that sits directly upstream of `eth_rx`. It samples the PHY's `crsdv`/`rxd` pins on the 50 MHz reference clock, validates and strips the preamble and SFD, and resolves the end-of-frame CRS_DV toggling. It then presents the frame body (MAC dst through CRC) as a gap-free dibit stream on `outclk`/`out`. Because `eth_rx` resets whenever `inclk` drops, `outclk` here is continuous from the first body dibit to the last.

## Interface
- `MIN_PREAMBLE`, 8: minimum count of `01` preamble dibits before an SFD is accepted.
- `MAX_FRAME_DIBITS`, 6072: maximum body length in dibits (1518 bytes × 4). Counter width is `clog2(MAX_FRAME_DIBITS+1)`.

- `clk` in 1: RMII 50 MHz reference clock, the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `crsdv` in 1: PHY CRS_DV, already synchronous to `clk`.
- `rxd` in 2: PHY RXD[1:0]; bit 0 is first on the wire.
- `outclk` out 1: `out` holds a valid body dibit.
- `out` out 2: body dibit, LSB-first order, passed unchanged.
- `done` out 1: single-cycle pulse; the frame ended cleanly.
- `err` out 1: single-cycle pulse; the frame or carrier was malformed.

## Operation
- Input pipeline: `crsdv_q`/`rxd_q` hold the previous cycle's inputs. The FSM always judges the delayed sample (`crsdv_q`, `rxd_q`), using the live `crsdv` as one-cycle lookahead.
- Sample validity: the delayed sample is "carrier" if `crsdv_q` is high, or if `crsdv_q` is low and `crsdv` is high (PHY toggle). "Line idle" means `crsdv_q` and `crsdv` are both low.
- States:
  - WAIT_IDLE (the reset state): wait for line idle, then go to IDLE. This ensures a reset released mid-frame never locks onto body data.
  - IDLE:
    - carrier with `rxd_q`=`00`: stay.
    - `01`: go to PREAMBLE with `pcnt`=1.
    - `10` or `11`: pulse `err` and go to WAIT_IDLE (false carrier).
  - PREAMBLE:
    - `01`: increment `pcnt`, saturating at `MIN_PREAMBLE`.
    - `11` with `pcnt`≥`MIN_PREAMBLE`: go to BODY with `bcnt`=0. The SFD is not forwarded.
    - `11` with `pcnt`<`MIN_PREAMBLE`, or `00`/`10`: pulse `err` and go to WAIT_IDLE.
    - line idle: go to IDLE silently.
  - BODY:
    - carrier sample: register `outclk`=1, `out`=`rxd_q`, and increment `bcnt`.
    - line idle: `outclk`=0 and go to IDLE. Pulse `done` if `bcnt`%4==0; otherwise pulse `err` (partial byte).
    - carrier with `bcnt`==`MAX_FRAME_DIBITS`: `outclk`=0, pulse `err`, go to WAIT_IDLE.
- `done` and `err` are mutually exclusive and never coincide with `outclk`=1.
- `out` is 0 whenever `outclk` is 0.

## Timing
- Reset values: `outclk`=0, `out`=0, `done`=0, `err`=0, state WAIT_IDLE, `crsdv_q`=0, `rxd_q`=0, `pcnt`=0, `bcnt`=0.
- Asserting `rst` mid-frame forces all outputs low immediately, with no `done`/`err`.
- All outputs are registered. A body dibit on the pins during cycle n appears on `out` during cycle n+2.
- The first `outclk` comes 2 cycles after the first body dibit, i.e. 3 cycles after the SFD cycle on the pins.
- `outclk` stays high with no gaps from the first body dibit through the last valid dibit, including across PHY toggles (low/high alternation of `crsdv`).
- `done`/`err` at end of frame: the last body dibit is on the pins at cycle L, and `crsdv` is low at L+1 and L+2. The last `outclk` is in cycle L+2 and `done`/`err` is in cycle L+3.
- Back-to-back frames need only one line-idle detection between them: IDLE accepts `01` on the cycle after the end is recognised.

## Test plan
- Nominal frame: 31×`01` + `11`, then 64 bytes (256 dibits, first byte 0xFF → dibits `11 11 11 11`), `crsdv` held high, then low.
  - Required: 256 contiguous `outclk` dibits matching the input, starting 2 cycles after the first body dibit.
  - `done` pulses once, one cycle after the last `outclk`; `err` never asserts.
- End toggle: same frame, but the last 8 dibits have `crsdv`=0,1,0,1,… with valid data.
  - Required: still 256 contiguous `outclk` and `done`, with no `outclk` gap.
- Short preamble: 4×`01` then `11`.
  - Required: `err` pulses one cycle after `11` is sampled, no `outclk`, and the next legal frame is received normally.
- Odd-length / false carrier:
  - A body of 255 dibits gives 255 `outclk` then `err` (not `done`).
  - `crsdv`=1 with `rxd`=`10` in IDLE gives an `err` pulse, and no output until the line is idle.
- Oversize: a body of 6080 dibits gives exactly 6072 `outclk` followed by `err`. Remaining input is ignored until the line is idle.
- Reset mid-BODY: assert `rst` at dibit 100 and release while `crsdv` is still high.
  - Required: outputs drop asynchronously, and the rest of the frame is ignored (no `outclk`/`err`/`done`).
  - The following frame is received with `done`.

Source files
------------

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble and SFD from the PHY dibit stream and
// forwards the frame body as a gap-free dibit stream with done/err status.
//
// state     | meaning
// WAIT_IDLE | ignore the line until crsdv is low on two consecutive samples
// IDLE      | line quiet, waiting for the first 01 preamble dibit
// PREAMBLE  | counting 01 dibits, looking for the 11 SFD
// BODY      | forwarding body dibits until the carrier ends
module rmii_rx_framer #(
  parameter int MIN_PREAMBLE     = 8,
  parameter int MAX_FRAME_DIBITS = 6072
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       outclk,
  output logic [1:0] out,
  output logic       done,
  output logic       err
);

  localparam int PW = $clog2(MIN_PREAMBLE + 1);
  localparam int BW = $clog2(MAX_FRAME_DIBITS + 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(MIN_PREAMBLE);
  localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_FRAME_DIBITS);

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_IDLE      = 2'd1,
    S_PREAMBLE  = 2'd2,
    S_BODY      = 2'd3
  } state_t;

  state_t          state_q;
  logic            crsdv_q;
  logic [1:0]      rxd_q;
  logic [PW-1:0]   pcnt_q;
  logic [BW-1:0]   bcnt_q;
  logic            outclk_q;
  logic [1:0]      out_q;
  logic            done_q;
  logic            err_q;
  logic            line_idle;

  // A low crsdv_q followed by a high crsdv is a PHY toggle, so the sample is
  // still carrier; only two lows in a row mean the frame is over.
  assign line_idle = !crsdv_q && !crsdv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_WAIT_IDLE;
      crsdv_q  <= 1'b0;
      rxd_q    <= 2'b00;
      pcnt_q   <= '0;
      bcnt_q   <= '0;
      outclk_q <= 1'b0;
      out_q    <= 2'b00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      crsdv_q  <= crsdv;
      rxd_q    <= rxd;
      outclk_q <= 1'b0;
      out_q    <= 2'b00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        S_WAIT_IDLE: begin
          if (line_idle) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (!line_idle) begin
            case (rxd_q)
              2'b00: state_q <= S_IDLE;
              2'b01: begin
                state_q <= S_PREAMBLE;
                pcnt_q  <= PW'(1);
              end
              default: begin
                err_q   <= 1'b1;
                state_q <= S_WAIT_IDLE;
              end
            endcase
          end
        end
        S_PREAMBLE: begin
          if (line_idle) begin
            state_q <= S_IDLE;
          end else if (rxd_q == 2'b01) begin
            if (pcnt_q != PCNT_MAX) pcnt_q <= pcnt_q + PW'(1);
          end else if (rxd_q == 2'b11 && pcnt_q >= PCNT_MAX) begin
            state_q <= S_BODY;
            bcnt_q  <= '0;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_WAIT_IDLE;
          end
        end
        S_BODY: begin
          if (line_idle) begin
            state_q <= S_IDLE;
            if (bcnt_q[1:0] == 2'b00) done_q <= 1'b1;
            else                      err_q  <= 1'b1;
          end else if (bcnt_q == BCNT_MAX) begin
            err_q   <= 1'b1;
            state_q <= S_WAIT_IDLE;
          end else begin
            outclk_q <= 1'b1;
            out_q    <= rxd_q;
            bcnt_q   <= bcnt_q + BW'(1);
          end
        end
        default: state_q <= S_WAIT_IDLE;
      endcase
    end
  end

  assign outclk = outclk_q;
  assign out    = out_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Bench for rmii_rx_framer: frame-level reference model feeds a timed
// expectation queue that a free-running monitor drains against the outputs.
module tb_rmii_rx_framer;

  localparam int MIN_PRE = 8;
  localparam int MAXD    = 6072;
  localparam int KD      = 0;
  localparam int KDONE   = 1;
  localparam int KERR    = 2;

  typedef struct {
    int         kind;
    logic [1:0] d;
    int         cyc;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       crsdv = 1'b0;
  logic [1:0] rxd   = 2'b00;
  logic       outclk;
  logic [1:0] out;
  logic       done;
  logic       err;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  rmii_rx_framer #(
    .MIN_PREAMBLE    (MIN_PRE),
    .MAX_FRAME_DIBITS(MAXD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .crsdv (crsdv),
    .rxd   (rxd),
    .outclk(outclk),
    .out   (out),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int k, input logic [1:0] d, input int c);
    exp_t e;
    e.kind = k;
    e.d    = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic check_pop(input int kind, input logic [1:0] d);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_output: kind=%0d d=%0d at cyc=%0d, nothing expected", kind, d, cyc);
    end else begin
      e = exp_q[0];
      exp_q.delete(0);
      if (e.kind != kind || (kind == KD && e.d != d) || e.cyc != cyc) begin
        bad++;
        $display("FAIL scoreboard: got kind=%0d d=%0d cyc=%0d, expected kind=%0d d=%0d cyc=%0d",
                 kind, d, cyc, e.kind, e.d, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_output: expected kind=%0d d=%0d at cyc=%0d, not seen by cyc=%0d",
                 exp_q[0].kind, exp_q[0].d, exp_q[0].cyc, cyc);
        exp_q.delete(0);
      end
      if (outclk) check_pop(KD, out);
      if (done)   check_pop(KDONE, 2'b00);
      if (err)    check_pop(KERR, 2'b00);
      if (!outclk) begin
        total++;
        if (out != 2'b00) begin
          bad++;
          $display("FAIL out_idle: got out=%0d with outclk low, expected 0", out);
        end
      end
    end
  end

  task automatic drive(input logic c, input logic [1:0] d, output int pc);
    @(posedge clk);
    #1;
    crsdv = c;
    rxd   = d;
    pc    = cyc;
  endtask

  // Frame-level model: a body is forwarded only after >= MIN_PRE 01s and an
  // 11 SFD; any bad SFD dibit errors two cycles after its pin cycle.
  task automatic send_frame(input int lead00, input int npre, input logic [1:0] sfd,
                            input int nbody, input int tail, input int gap, input bit ff_first);
    int         pc;
    logic [1:0] d;
    logic       c;
    bit         good;
    good = (npre >= MIN_PRE) && (sfd == 2'b11);
    for (int i = 0; i < lead00; i++) drive(1'b1, 2'b00, pc);
    for (int i = 0; i < npre; i++)   drive(1'b1, 2'b01, pc);
    drive(1'b1, sfd, pc);
    if (!good) push(KERR, 2'b00, pc + 2);
    for (int i = 0; i < nbody; i++) begin
      d = (ff_first && i < 4) ? 2'b11 : 2'($urandom_range(0, 3));
      c = (i >= nbody - tail) ? ((i - (nbody - tail)) % 2 == 1) : 1'b1;
      drive(c, d, pc);
      if (good && i < MAXD)  push(KD, d, pc + 2);
      if (good && i == MAXD) push(KERR, 2'b00, pc + 2);
    end
    if (good && nbody <= MAXD) push((nbody % 4 == 0) ? KDONE : KERR, 2'b00, pc + 3);
    for (int i = 0; i < gap; i++) drive(1'b0, 2'b00, pc);
  endtask

  task automatic false_carrier(input logic [1:0] bad_d, input int junk, input int gap);
    int pc;
    drive(1'b1, bad_d, pc);
    push(KERR, 2'b00, pc + 2);
    for (int i = 0; i < junk; i++) drive(1'b1, 2'($urandom_range(0, 3)), pc);
    for (int i = 0; i < gap; i++)  drive(1'b0, 2'b00, pc);
  endtask

  task automatic reset_mid_frame();
    int         pc;
    logic [1:0] d;
    for (int i = 0; i < 8; i++) drive(1'b1, 2'b01, pc);
    drive(1'b1, 2'b11, pc);
    for (int i = 0; i < 256; i++) begin
      d = 2'($urandom_range(0, 3));
      drive(1'b1, d, pc);
      // reset lands inside dibit 100's pin cycle, before dibit 98 is sampled
      if (i < 98) push(KD, d, pc + 2);
      if (i == 100) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_async_outclk", int'(outclk), 0);
        chk("rst_async_out",    int'(out),    0);
        chk("rst_async_done",   int'(done),   0);
        chk("rst_async_err",    int'(err),    0);
      end
      if (i == 103) #1 rst = 1'b0;
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, pc);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         pc;
    int         nbody;
    int         tail;
    int         r;
    logic [1:0] sfd;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outclk", int'(outclk), 0);
    chk("reset_out",    int'(out),    0);
    chk("reset_done",   int'(done),   0);
    chk("reset_err",    int'(err),    0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, pc);

    send_frame(0, 31, 2'b11, 256, 0, 3, 1'b1);
    send_frame(0, 31, 2'b11, 256, 8, 3, 1'b1);
    send_frame(0, 4,  2'b11, 20,  0, 3, 1'b0);
    send_frame(0, 31, 2'b11, 256, 0, 3, 1'b1);
    send_frame(0, 12, 2'b11, 255, 0, 3, 1'b0);
    false_carrier(2'b10, 30, 3);
    send_frame(2, 8,  2'b11, 64,  0, 2, 1'b0);
    send_frame(0, 10, 2'b11, 6080, 0, 3, 1'b0);
    send_frame(0, 9,  2'b11, 40,  0, 3, 1'b0);
    reset_mid_frame();
    send_frame(0, 31, 2'b11, 256, 0, 3, 1'b1);

    for (int n = 0; n < 30; n++) begin
      r   = int'($urandom_range(0, 5));
      sfd = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
      nbody = 4 * int'($urandom_range(1, 80));
      if ($urandom_range(0, 3) == 0) nbody = nbody - int'($urandom_range(1, 3));
      tail = 2 * int'($urandom_range(0, 4));
      if (tail > nbody - 1) tail = 0;
      if ($urandom_range(0, 7) == 0)
        false_carrier(2'($urandom_range(2, 3)), int'($urandom_range(0, 20)), int'($urandom_range(2, 5)));
      send_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 20)), sfd,
                 nbody, tail, int'($urandom_range(2, 5)), 1'b0);
    end

    for (int i = 0; i < 10; i++) drive(1'b0, 2'b00, pc);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
